// File: rtl/fifo_rr_wr_arb_pkg.sv
// rtl/fifo_rr_wr_arb_pkg.sv - shared types and helpers for the round-robin FIFO write arbiter
package fifo_rr_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_BUS_W = 1024;
    localparam int MAX_PAY_W = 256;

    // Source-id width; a 2-requester arbiter still needs one tag bit.
    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_PAY_W-1:0] slice_payload(input logic [MAX_BUS_W-1:0] req_data,
                                                           input int idx, input int dataw);
        return MAX_PAY_W'(req_data >> (idx * dataw));
    endfunction

endpackage

// File: rtl/fifo_rr_wr_arb_if.sv
// rtl/fifo_rr_wr_arb_if.sv - requester handshake and FIFO write-port bundle
interface fifo_rr_wr_arb_if
    import fifo_rr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DATAW = 8
) ();
    localparam int IDW = idw_f(NREQ);

    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ*DATAW-1:0] i_req_data;
    logic [NREQ-1:0]       i_req_last;
    logic [NREQ-1:0]       o_req_ready;
    logic                  o_fifo_wr_en;
    logic [IDW+DATAW-1:0]  o_fifo_wr_data;
    logic                  i_fifo_full;
    logic [IDW-1:0]        o_grant_id;
    logic                  o_busy;

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_fifo_full,
        input  o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_grant_id, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
        output o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_grant_id, o_busy
    );

endinterface

// File: rtl/fifo_rr_wr_arb_rr_pick.sv
// rtl/fifo_rr_wr_arb_rr_pick.sv - combinational rotating-priority picker
module rr_pick
    import fifo_rr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  base,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(base) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (req[k]) begin
                any    = 1'b1;
                idx    = IDW'(k);
                gnt    = '0;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_wr_arb.sv
// rtl/fifo_rr_wr_arb.sv - round-robin write arbiter for a shared FIFO; packet lock under FIFO_RR_ARB_PKT_LOCK_EN
module fifo_rr_wr_arb
    import fifo_rr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DATAW = 8
) (
    input logic              clk,
    input logic              rst_n,
    fifo_rr_wr_arb_if.slave  bus
);
    localparam int IDW = idw_f(NREQ);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  prio_q, prio_d;
    logic [IDW-1:0]  own_q, own_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  sel;
    logic            xfer;
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [DATAW-1:0] payload;
    logic            wr_en;

    function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] x);
        return (int'(x) == NREQ - 1) ? '0 : x + IDW'(1);
    endfunction

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req  (bus.i_req_valid),
        .base (prio_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Full freezes everything: no ready, no write, no state or pointer movement.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        own_d      = own_q;
        grant_id_d = grant_id_q;
        ready      = '0;
        sel        = '0;
        xfer       = 1'b0;
        if (rst_n && !bus.i_fifo_full) begin
            if (state_q == ST_LOCKED) begin
                ready[own_q] = 1'b1;
                sel          = own_q;
                xfer         = bus.i_req_valid[own_q];
                if (xfer && bus.i_req_last[own_q]) begin
                    state_d = ST_IDLE;
                    prio_d  = inc_mod(own_q);
                end
            end else if (pick_any) begin
                ready = pick_gnt;
                sel   = pick_idx;
                xfer  = 1'b1;
`ifdef FIFO_RR_ARB_PKT_LOCK_EN
                if (!bus.i_req_last[pick_idx]) begin
                    state_d = ST_LOCKED;
                    own_d   = pick_idx;
                end else begin
                    prio_d  = inc_mod(pick_idx);
                end
`else
                prio_d = inc_mod(pick_idx);
`endif
            end
        end
        if (xfer) begin
            grant_id_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            prio_q     <= '0;
            own_q      <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            own_q      <= own_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign payload = DATAW'(slice_payload(MAX_BUS_W'(bus.i_req_data), int'(sel), DATAW));
    assign wr_en   = |(bus.i_req_valid & ready);

    assign bus.o_req_ready    = ready;
    assign bus.o_fifo_wr_en   = wr_en;
    assign bus.o_fifo_wr_data = wr_en ? {sel, payload} : '0;
    assign bus.o_grant_id     = grant_id_q;
    assign bus.o_busy         = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fifo_rr_wr_arb.sv
// tb/tb_fifo_rr_wr_arb.sv - scoreboard bench for fifo_rr_wr_arb
module tb_fifo_rr_wr_arb;
    import fifo_rr_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int DATAW = 8;
    localparam int IDW   = 2;
`ifdef FIFO_RR_ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_rr_wr_arb_if #(.NREQ(NREQ), .DATAW(DATAW)) bus ();

    fifo_rr_wr_arb #(.NREQ(NREQ), .DATAW(DATAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [IDW+DATAW-1:0] sb[$];

    int m_prio   = 0;
    int m_own    = 0;
    int m_gid    = 0;
    bit m_locked = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at posedge+1; samples at posedge+4 and returns at the next posedge+1.
    task automatic step(input logic [NREQ-1:0] v, input logic f, input logic [NREQ-1:0] l);
        logic [NREQ-1:0]       exp_ready;
        logic [NREQ*DATAW-1:0] d;
        int  w;
        bit  xfer;
        bit  found;
        d = (NREQ*DATAW)'($urandom);
        bus.i_req_valid = v;
        bus.i_fifo_full = f;
        bus.i_req_last  = l;
        bus.i_req_data  = d;
        exp_ready = '0;
        xfer      = 1'b0;
        found     = 1'b0;
        w         = 0;
        if (!f) begin
            if (m_locked) begin
                exp_ready[m_own] = 1'b1;
                w    = m_own;
                xfer = v[m_own];
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && v[(m_prio + i) % NREQ]) begin
                        found = 1'b1;
                        w     = (m_prio + i) % NREQ;
                    end
                end
                if (found) begin
                    exp_ready[w] = 1'b1;
                    xfer         = 1'b1;
                end
            end
        end
        if (xfer) sb.push_back({IDW'(w), d[w*DATAW +: DATAW]});
        #3;
        check_eq("ready", 32'(bus.o_req_ready), 32'(exp_ready));
        check_eq("wr_en", 32'(bus.o_fifo_wr_en), 32'(xfer));
        if (bus.o_fifo_wr_en) begin
            if (sb.size() == 0) check_eq("sb_pending", 0, 1);
            else check_eq("wr_data", 32'(bus.o_fifo_wr_data), 32'(sb.pop_front()));
        end else begin
            check_eq("wr_data_idle", 32'(bus.o_fifo_wr_data), 0);
        end
        check_eq("busy", 32'(bus.o_busy), 32'(m_locked));
        check_eq("grant_id", 32'(bus.o_grant_id), 32'(m_gid));
        @(posedge clk);
        #1;
        if (xfer) begin
            m_gid = w;
            if (m_locked) begin
                if (l[w]) begin
                    m_locked = 1'b0;
                    m_prio   = (w + 1) % NREQ;
                end
            end else if (LOCK_EN && !l[w]) begin
                m_locked = 1'b1;
                m_own    = w;
            end else begin
                m_prio = (w + 1) % NREQ;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.o_req_ready), 0);
        check_eq({tag, "_wr_en"}, 32'(bus.o_fifo_wr_en), 0);
        check_eq({tag, "_wr_data"}, 32'(bus.o_fifo_wr_data), 0);
        check_eq({tag, "_busy"}, 32'(bus.o_busy), 0);
        check_eq({tag, "_grant_id"}, 32'(bus.o_grant_id), 0);
    endtask

    initial begin
        bus.i_req_valid = '1;
        bus.i_req_data  = 32'hA5C3_0F96;
        bus.i_req_last  = '1;
        bus.i_fifo_full = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round robin across all four, then a single persistent requester.
        repeat (4) step(4'b1111, 1'b0, 4'b1111);
        repeat (3) step(4'b0100, 1'b0, 4'b1111);

        // Full blocks; once it drops, prio=3 wraps to req 0.
        repeat (2) step(4'b0101, 1'b1, 4'b1111);
        step(4'b0101, 1'b0, 4'b1111);

        if (LOCK_EN) begin
            step(4'b1011, 1'b0, 4'b0000);
            step(4'b1011, 1'b0, 4'b0000);
            step(4'b1011, 1'b0, 4'b0010);
            step(4'b1001, 1'b0, 4'b1111);
            step(4'b0010, 1'b0, 4'b0000);
            repeat (2) step(4'b0001, 1'b0, 4'b0000);
            step(4'b1011, 1'b1, 4'b0010);
            step(4'b0011, 1'b0, 4'b0010);
        end

        repeat (60) step(NREQ'($urandom), ($urandom_range(0, 3) == 0), NREQ'($urandom));

        // Leave a packet in flight (locks when enabled), then reset asynchronously.
        step(4'b1111, 1'b0, 4'b1111);
        step(4'b1111, 1'b0, 4'b0000);
        bus.i_req_valid = '1;
        bus.i_fifo_full = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_prio   = 0;
        m_own    = 0;
        m_gid    = 0;
        m_locked = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (4) step(4'b1111, 1'b0, 4'b1111);

        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
